// File: rtl/demux_pkg.sv
// demux_pkg: shared parameter defaults and select-width helper for demux_stream
package demux_pkg;
  localparam int DEF_ELEM_WIDTH = 8;
  localparam int DEF_NUM_ELEM = 6;
  localparam int DEF_SEL_WIDTH = $clog2(DEF_NUM_ELEM);
  typedef logic [DEF_SEL_WIDTH-1:0] sel_t;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/demux_stream_decoder.sv
// demux_stream_decoder: binary lane index to one-hot select, gated by an enable
module demux_stream_decoder import demux_pkg::*; #(
  parameter int N = DEF_NUM_ELEM,
  parameter int W = sel_width(DEF_NUM_ELEM)
) (
  input  logic         en,
  input  logic [W-1:0] idx,
  output logic [N-1:0] oh
);
  // one bit per lane; an index with no matching lane yields all zeros
  always_comb begin
    oh = '0;
    for (int i = 0; i < N; i++) oh[i] = en && (int'(idx) == i);
  end
endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NUM_ELEM stream demux; DEMUX_SEL_CHECK_EN drops out-of-range beats and pulses err_o
module demux_stream import demux_pkg::*; #(
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int NUM_ELEM = DEF_NUM_ELEM,
  localparam int SEL_WIDTH = sel_width(NUM_ELEM)
) (
  input  logic                               clk_i,
  input  logic                               arst_ni,
  input  logic [SEL_WIDTH-1:0]               s_i,
  input  logic [ELEM_WIDTH-1:0]              i_data_i,
  input  logic                               i_valid_i,
  output logic                               i_ready_o,
  output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] o_data_o,
  output logic [NUM_ELEM-1:0]                o_valid_o,
  input  logic [NUM_ELEM-1:0]                o_ready_i,
  output logic                               err_o
);
  logic                  full_q;
  logic [ELEM_WIDTH-1:0] data_q;
  logic [SEL_WIDTH-1:0]  dest_q;
  logic [NUM_ELEM-1:0]   lane_oh;
  logic                  drain;
  logic                  accept;
  logic                  load;
  demux_stream_decoder #(.N(NUM_ELEM), .W(SEL_WIDTH)) u_decoder (
    .en (full_q),
    .idx(dest_q),
    .oh (lane_oh)
  );
  assign drain = |(lane_oh & o_ready_i);
  assign i_ready_o = !full_q || drain;
  assign accept = i_valid_i && i_ready_o;
  assign o_valid_o = lane_oh;
  // only the selected lane carries the held beat, all others read zero
  always_comb begin
    for (int i = 0; i < NUM_ELEM; i++) o_data_o[i] = lane_oh[i] ? data_q : '0;
  end
`ifdef DEMUX_SEL_CHECK_EN
  logic in_range;
  assign in_range = int'(s_i) < NUM_ELEM;
  assign load = accept && in_range;
  // out-of-range beat is consumed but never stored; flag it for one cycle
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) err_o <= 1'b0;
    else err_o <= accept && !in_range;
  end
`else
  assign load = accept;
  assign err_o = 1'b0;
`endif
  // single pipeline slot: reload on accept, empty on drain, otherwise hold
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
      dest_q <= '0;
    end else begin
      full_q <= load || (full_q && !drain);
      if (load) begin
        data_q <= i_data_i;
        dest_q <= s_i;
      end
    end
  end
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: randomized self-checking bench for demux_stream against a queue model
module tb_demux_stream;
  localparam int N = 6;
  localparam int EW = 8;
`ifdef DEMUX_SEL_CHECK_EN
  localparam int SMAX = 7;
`else
  localparam int SMAX = N - 1;
`endif
  typedef struct packed {logic [2:0] dst; logic [7:0] dat;} beat_t;
  logic clk, arst_ni;
  logic [2:0] s_i;
  logic [EW-1:0] i_data_i;
  logic i_valid_i, i_ready_o, err_o;
  logic [N-1:0][EW-1:0] o_data_o;
  logic [N-1:0] o_valid_o, o_ready_i;
  int total = 0, bad = 0;
  beat_t q[$];
  logic err_exp;
  logic acc;
  demux_stream #(.ELEM_WIDTH(EW), .NUM_ELEM(N)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .s_i(s_i), .i_data_i(i_data_i),
    .i_valid_i(i_valid_i), .i_ready_o(i_ready_o), .o_data_o(o_data_o),
    .o_valid_o(o_valid_o), .o_ready_i(o_ready_i), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    arst_ni = 1'b0;
    q.delete();
    err_exp = 1'b0;
    #1;
    chk("rst_valid", o_valid_o, 0);
    chk("rst_data", o_data_o, 0);
    chk("rst_ready", i_ready_o, 1);
    chk("rst_err", err_o, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_valid", o_valid_o, 0);
    chk("rst_hold_ready", i_ready_o, 1);
    arst_ni = 1'b1;
  endtask
  task automatic cyc(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [5:0] r, output logic a);
    logic [N-1:0] ev;
    logic [N-1:0][EW-1:0] ed;
    logic er, drn;
    i_valid_i = v;
    s_i = s;
    i_data_i = d;
    o_ready_i = r;
`ifndef DEMUX_SEL_CHECK_EN
    if (v) assert (int'(s) < N) else $error("illegal select %0d", s);
`endif
    ev = '0;
    ed = '0;
    er = 1'b1;
    drn = 1'b0;
    if (q.size() != 0) begin
      ev[q[0].dst] = 1'b1;
      ed[q[0].dst] = q[0].dat;
      drn = r[q[0].dst];
      er = drn;
    end
    #1;
    chk("i_ready", i_ready_o, er);
    chk("o_valid", o_valid_o, ev);
    chk("o_data", o_data_o, ed);
    chk("err", err_o, err_exp);
    a = v && er;
    @(posedge clk);
    if (drn) void'(q.pop_front());
    err_exp = a && int'(s) >= N;
    if (a && int'(s) < N) q.push_back('{dst: s, dat: d});
    @(negedge clk);
  endtask
  initial begin
    logic pv;
    logic [2:0] ps;
    logic [7:0] pd;
    clk = 1'b0;
    arst_ni = 1'b1;
    i_valid_i = 1'b1;
    s_i = 3'd3;
    i_data_i = 8'h5A;
    o_ready_i = '1;
    err_exp = 1'b0;
    @(negedge clk);
    do_reset();
    cyc(1, 3, 8'hA5, 6'h3F, acc);
    chk("single_valid", o_valid_o, 6'b001000);
    chk("single_data", o_data_o[3], 8'hA5);
    chk("single_other", o_data_o[2], 8'h00);
    cyc(0, 0, 0, 6'h3F, acc);
    for (int i = 0; i < N; i++) cyc(1, 3'(i), 8'(i + 1), 6'h3F, acc);
    cyc(0, 0, 0, 6'h3F, acc);
    cyc(1, 2, 8'h3C, 6'b111011, acc);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 5, 8'h99, 6'b111011, acc);
      chk("bp_hold", o_data_o[2], 8'h3C);
      chk("bp_stall", i_ready_o, 0);
    end
    cyc(1, 5, 8'h99, 6'h3F, acc);
    chk("bp_reload", o_valid_o, 6'b100000);
    cyc(0, 0, 0, 6'h3F, acc);
`ifdef DEMUX_SEL_CHECK_EN
    cyc(1, 1, 8'h11, 6'h3F, acc);
    cyc(1, 7, 8'hFF, 6'h3F, acc);
    chk("oor_err", err_o, 1);
    chk("oor_valid", o_valid_o, 0);
    cyc(0, 0, 0, 6'h3F, acc);
`endif
    cyc(1, 4, 8'h77, 6'h3F, acc);
    cyc(0, 0, 0, 6'b101111, acc);
    chk("stall_valid", o_valid_o, 6'b010000);
    do_reset();
    cyc(0, 0, 0, 6'h3F, acc);
    pv = 1'b0;
    ps = '0;
    pd = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!pv) begin
        pv = $urandom_range(0, 3) != 0;
        ps = 3'($urandom_range(0, SMAX));
        pd = 8'($urandom);
      end
      cyc(pv, ps, pd, 6'($urandom | $urandom), acc);
      if (acc) pv = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
